// File: rtl/fetch_ctrl.sv
// fetch_ctrl: request-side partner of the fetch stage.
// Owns the program counter and issues fetch requests on a credit basis, so
// the in-order instruction buffer can never overflow. Each returned
// instruction/PC pair is buffered and handed to decode through a
// valid/ready handshake. A jump flushes buffered and in-flight work and
// restarts fetch at the (halfword-aligned) jump target.
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        fetch_en,
    output logic [15:0] fetch_addr,
    input  logic        fetch_ready,
    input  logic [15:0] fetch_instr,
    input  logic [15:0] fetch_pc,
    input  logic        jump_valid,
    input  logic [15:0] jump_target,
    output logic        dec_valid,
    output logic [15:0] dec_instr,
    output logic [15:0] dec_pc,
    input  logic        dec_ready,
    output logic        proto_err
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    localparam logic [OCC_W:0]   DEPTH_CREDIT = (OCC_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR     = PTR_W'(BUF_DEPTH - 1);
    localparam logic [15:0]      RESET_PC_AL  = {RESET_PC[15:1], 1'b0};

    // Architectural state
    logic [15:0]      pc_reg, pc_next;
    logic [OCC_W-1:0] occ_reg, occ_next;
    logic             inflight_reg, inflight_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic             proto_err_reg, proto_err_next;
    // High for the first cycle after reset releases: a response seen then
    // belongs to a request issued before reset and must be ignored.
    logic             resp_mask_reg;

    // Buffer storage (no reset needed: occupancy qualifies every entry)
    logic [15:0] instr_mem [BUF_DEPTH];
    logic [15:0] pc_mem    [BUF_DEPTH];

    // Handshake / credit signals
    logic           pop;
    logic           push;
    logic           proto_hit;
    logic           resp_valid;
    logic [OCC_W:0] demand;
    logic [15:0]    jump_pc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Decode-side view of the buffer head; suppressed while reset is high
    always_comb begin
        dec_valid = !reset && (occ_reg != '0);
        dec_instr = instr_mem[rd_ptr_reg];
        dec_pc    = pc_mem[rd_ptr_reg];
        pop       = dec_valid && dec_ready;
    end

    // Credit check: issue only if every occupied, in-flight and new slot fits
    always_comb begin
        demand     = {1'b0, occ_reg} + (OCC_W + 1)'(inflight_reg) - (OCC_W + 1)'(pop);
        fetch_en   = !reset && !jump_valid && (demand < DEPTH_CREDIT);
        fetch_addr = pc_reg;
        proto_err  = proto_err_reg;
        jump_pc    = jump_target & 16'hFFFE;
        resp_valid = fetch_ready && !jump_valid && !resp_mask_reg;
        push       = resp_valid && inflight_reg;
        proto_hit  = resp_valid && !inflight_reg;
    end

    // Next-state logic: a jump overrides issue, capture and retire
    always_comb begin
        pc_next        = pc_reg;
        occ_next       = occ_reg;
        inflight_next  = fetch_en;
        rd_ptr_next    = rd_ptr_reg;
        wr_ptr_next    = wr_ptr_reg;
        proto_err_next = proto_err_reg;
        if (jump_valid) begin
            pc_next       = jump_pc;
            occ_next      = '0;
            rd_ptr_next   = wr_ptr_reg;
            inflight_next = 1'b0;
        end else begin
            if (fetch_en) begin
                pc_next = pc_reg + 16'd2;
            end
            if (push) begin
                wr_ptr_next = ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_next = ptr_inc(rd_ptr_reg);
            end
            if (push && !pop) begin
                occ_next = occ_reg + OCC_W'(1);
            end else if (pop && !push) begin
                occ_next = occ_reg - OCC_W'(1);
            end
            if (proto_hit) begin
                proto_err_next = 1'b1;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg        <= RESET_PC_AL;
            occ_reg       <= '0;
            inflight_reg  <= 1'b0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            proto_err_reg <= 1'b0;
            resp_mask_reg <= 1'b1;
        end else begin
            pc_reg        <= pc_next;
            occ_reg       <= occ_next;
            inflight_reg  <= inflight_next;
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            proto_err_reg <= proto_err_next;
            resp_mask_reg <= 1'b0;
        end
    end

    // Buffer write: capture the returned instruction/PC at the write pointer
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            instr_mem[wr_ptr_reg] <= fetch_instr;
            pc_mem[wr_ptr_reg]    <= fetch_pc;
        end
    end

endmodule
